// File: rtl/icu80186_pkg.sv
// Shared constants for the 80186-style interrupt control unit.
// Register offsets, source indices and control-register field positions.
package icu80186_pkg;

  localparam int NSRC   = 5;
  localparam int PR_W   = 3;
  localparam int TYPE_W = 5;
  localparam int DAT_W  = 16;
  localparam int ADR_W  = 4;

  localparam logic [ADR_W-1:0] OFF_EOI     = 4'h1;
  localparam logic [ADR_W-1:0] OFF_POLL    = 4'h2;
  localparam logic [ADR_W-1:0] OFF_POLLSTS = 4'h3;
  localparam logic [ADR_W-1:0] OFF_MASK    = 4'h4;
  localparam logic [ADR_W-1:0] OFF_PRIMSK  = 4'h5;
  localparam logic [ADR_W-1:0] OFF_INSERV  = 4'h6;
  localparam logic [ADR_W-1:0] OFF_REQST   = 4'h7;
  localparam logic [ADR_W-1:0] OFF_TCUCON  = 4'h9;
  localparam logic [ADR_W-1:0] OFF_I0CON   = 4'hC;
  localparam logic [ADR_W-1:0] OFF_I1CON   = 4'hD;
  localparam logic [ADR_W-1:0] OFF_I2CON   = 4'hE;
  localparam logic [ADR_W-1:0] OFF_I3CON   = 4'hF;

  localparam int SRC_TMR  = 0;
  localparam int SRC_INT0 = 1;
  localparam int SRC_INT1 = 2;
  localparam int SRC_INT2 = 3;
  localparam int SRC_INT3 = 4;

  localparam int CON_PR  = 0;
  localparam int CON_MSK = 3;
  localparam int CON_LTM = 4;

  localparam logic [DAT_W-1:0] CON_RST = 16'h000F;

  // Source vector <-> register bit map (bit0 TMR, bits 4..7 INT0..3)
  function automatic logic [DAT_W-1:0] src_map(input logic [NSRC-1:0] s);
    return {8'h00, s[SRC_INT3:SRC_INT0], 3'b000, s[SRC_TMR]};
  endfunction

  function automatic logic [NSRC-1:0] map_src(input logic [DAT_W-1:0] d);
    return {d[7:4], d[0]};
  endfunction

endpackage

// File: rtl/icu80186_prio_resolve.sv
// Picks the lowest-PR valid source; ties resolve to the lowest index.
// Used for both the pending-request and the in-service sets.
module icu_prio_resolve
  import icu80186_pkg::*;
(
  input  logic [NSRC-1:0]      valid_i,
  input  logic [NSRC*PR_W-1:0] pr_i,
  output logic [NSRC-1:0]      win_o,
  output logic [PR_W-1:0]      pr_o,
  output logic                 any_o
);

  always_comb begin
    win_o = '0;
    pr_o  = '1;
    any_o = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (valid_i[i] &&
          (!any_o || pr_i[i*PR_W +: PR_W] < pr_o)) begin
        win_o    = '0;
        win_o[i] = 1'b1;
        pr_o     = pr_i[i*PR_W +: PR_W];
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_icu80186.sv
// 80186-compatible interrupt controller (master subset) on a Wishbone slave.
// Define ICU_POLL_EN to enable the POLL / POLLSTS registers.
module wb_icu80186
  import icu80186_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TMR_TYPE    = 8,
  parameter int INT0_TYPE   = 12
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [3:0]  wb_adr_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [3:0]  int_i,
  input  logic        tmr_i,
  output logic        intr_o,
  input  logic        inta_i,
  output logic [7:0]  vector_o
);

  function automatic logic [7:0] src_type(input int i);
    return (i == SRC_TMR) ? 8'(TMR_TYPE) : 8'(INT0_TYPE + i - 1);
  endfunction

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  lvl_q, lvl_d;
  logic [NSRC-1:0][PR_W-1:0]   pr_q, pr_d;
  logic [NSRC-1:0]             msk_q, msk_d;
  logic [3:0]                  ltm_q, ltm_d;
  logic [PR_W-1:0]             primsk_q, primsk_d;
  logic [NSRC-1:0]             reqst_q, reqst_d;
  logic [NSRC-1:0]             inserv_q, inserv_d;
  logic                        intr_q, intr_d;
  logic [7:0]                  vec_q, vec_d;
  logic                        ack_q, ack_d;
  logic [15:0]                 dat_q, dat_d;
  logic                        inta_q, inta_d;

  logic [3:0]      int_s, int_rise;
  logic [NSRC-1:0] elig, win, is_win, eoi_sp;
  logic [PR_W-1:0] rq_pr, is_pr;
  logic            rq_any, is_any, win_ok;
  logic [7:0]      win_vec;
  logic            acc, wr, rd, inta_rise, poll_evt, ack_evt;
  logic            eoi_wr, eoi_ns;
  logic [15:0]     rdata;
  logic [2:0]      ci;

  assign int_s    = sync_q[SYNC_STAGES-1];
  assign int_rise = int_s & ~lvl_q;

  icu_prio_resolve u_is (
    .valid_i (inserv_q),
    .pr_i    (pr_q),
    .win_o   (is_win),
    .pr_o    (is_pr),
    .any_o   (is_any)
  );

  always_comb begin
    elig = '0;
    for (int i = 0; i < NSRC; i++) begin
      elig[i] = reqst_q[i] & ~msk_q[i] & (pr_q[i] <= primsk_q) &
                (~is_any | (pr_q[i] < is_pr));
    end
  end

  icu_prio_resolve u_rq (
    .valid_i (elig),
    .pr_i    (pr_q),
    .win_o   (win),
    .pr_o    (rq_pr),
    .any_o   (rq_any)
  );

  assign win_ok = rq_any & (~is_any | (rq_pr < is_pr));

  always_comb begin
    win_vec = '0;
    eoi_sp  = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (win[i]) win_vec = src_type(i);
      eoi_sp[i] = ({3'b000, wb_dat_i[4:0]} == src_type(i));
    end
  end

  assign acc       = wb_stb_i & wb_cyc_i & ~ack_q;
  assign wr        = acc & wb_we_i;
  assign rd        = acc & ~wb_we_i;
  assign inta_rise = inta_i & ~inta_q;
`ifdef ICU_POLL_EN
  assign poll_evt  = rd & (wb_adr_i == OFF_POLL);
`else
  assign poll_evt  = 1'b0;
`endif
  assign ack_evt   = (inta_rise | poll_evt) & win_ok;
  assign eoi_wr    = wr & (wb_adr_i == OFF_EOI);
  assign eoi_ns    = wb_sel_i[1] & wb_dat_i[15];
  assign ci        = {1'b0, wb_adr_i[1:0]} + 3'd1;

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
`ifdef ICU_POLL_EN
      OFF_POLL,
      OFF_POLLSTS: rdata = {win_ok, 10'b0, win_vec[TYPE_W-1:0]};
`endif
      OFF_MASK:    rdata = src_map(msk_q);
      OFF_PRIMSK:  rdata = {13'b0, primsk_q};
      OFF_INSERV:  rdata = src_map(inserv_q);
      OFF_REQST:   rdata = src_map(reqst_q);
      OFF_TCUCON:  rdata = {12'b0, msk_q[SRC_TMR], pr_q[SRC_TMR]};
      OFF_I0CON, OFF_I1CON, OFF_I2CON, OFF_I3CON:
        rdata = {11'b0, ltm_q[wb_adr_i[1:0]], msk_q[ci], pr_q[ci]};
      default:     rdata = '0;
    endcase
  end

  always_comb begin
    pr_d     = pr_q;
    msk_d    = msk_q;
    ltm_d    = ltm_q;
    primsk_d = primsk_q;
    if (wr && wb_sel_i[0]) begin
      case (wb_adr_i)
        OFF_MASK:   msk_d = map_src(wb_dat_i);
        OFF_PRIMSK: primsk_d = wb_dat_i[2:0];
        OFF_TCUCON: begin
          pr_d[SRC_TMR]  = wb_dat_i[CON_PR +: PR_W];
          msk_d[SRC_TMR] = wb_dat_i[CON_MSK];
        end
        OFF_I0CON, OFF_I1CON, OFF_I2CON, OFF_I3CON: begin
          pr_d[ci]               = wb_dat_i[CON_PR +: PR_W];
          msk_d[ci]              = wb_dat_i[CON_MSK];
          ltm_d[wb_adr_i[1:0]]   = wb_dat_i[CON_LTM];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    sync_d[0] = int_i;
    for (int s = 1; s < SYNC_STAGES; s++) sync_d[s] = sync_q[s-1];
    lvl_d = int_s;

    reqst_d = reqst_q;
    if (wr && wb_sel_i[0] && wb_adr_i == OFF_REQST)
      reqst_d = map_src(wb_dat_i);
    if (ack_evt) reqst_d = reqst_d & ~(win & {~ltm_q, 1'b1});
    // Set events applied last so they beat any same-cycle clear
    reqst_d = reqst_d | {int_rise & ~ltm_q, tmr_i};
    for (int n = 0; n < 4; n++)
      if (ltm_q[n]) reqst_d[n+1] = int_s[n];

    inserv_d = inserv_q;
    if (ack_evt) inserv_d = inserv_d | win;
    if (eoi_wr) begin
      if (eoi_ns)
        inserv_d = inserv_d & ~(ack_evt ? win : is_win);
      else if (wb_sel_i[0])
        inserv_d = inserv_d & ~eoi_sp;
    end

    intr_d = win_ok & ~inta_i;
    vec_d  = vec_q;
    if (!inta_i) begin
      if (win_ok) vec_d = win_vec;
    end else if (inta_rise) begin
      vec_d = win_ok ? win_vec : 8'h0F;
    end

    inta_d = inta_i;
    ack_d  = acc;
    dat_d  = rd ? rdata : 16'h0000;
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      sync_q   <= '0;
      lvl_q    <= '0;
      pr_q     <= '1;
      msk_q    <= '1;
      ltm_q    <= '0;
      primsk_q <= '1;
      reqst_q  <= '0;
      inserv_q <= '0;
      intr_q   <= 1'b0;
      vec_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      inta_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      lvl_q    <= lvl_d;
      pr_q     <= pr_d;
      msk_q    <= msk_d;
      ltm_q    <= ltm_d;
      primsk_q <= primsk_d;
      reqst_q  <= reqst_d;
      inserv_q <= inserv_d;
      intr_q   <= intr_d;
      vec_q    <= vec_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      inta_q   <= inta_d;
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign intr_o   = intr_q;
  assign vector_o = vec_q;

endmodule

// File: tb/tb_wb_icu80186.sv
// Directed-vector bench for wb_icu80186.
// Covers reset, edge/level modes, nesting, EOI forms, TMR and POLL.
module tb_wb_icu80186;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic [3:0]  wb_adr = '0;
  logic [15:0] wb_dat = '0;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel = 2'b11;
  logic        wb_we = 1'b0;
  logic        wb_stb = 1'b0;
  logic        wb_cyc = 1'b0;
  logic        wb_ack_o;
  logic [3:0]  int_i = '0;
  logic        tmr_i = 1'b0;
  logic        intr_o;
  logic        inta_i = 1'b0;
  logic [7:0]  vector_o;

  int ncmp = 0;
  int nfail = 0;
  logic [7:0] ivec;
  logic       iintr;

  always #5 clk = ~clk;

  wb_icu80186 dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .wb_adr_i (wb_adr),
    .wb_dat_i (wb_dat),
    .wb_dat_o (wb_dat_o),
    .wb_sel_i (wb_sel),
    .wb_we_i  (wb_we),
    .wb_stb_i (wb_stb),
    .wb_cyc_i (wb_cyc),
    .wb_ack_o (wb_ack_o),
    .int_i    (int_i),
    .tmr_i    (tmr_i),
    .intr_o   (intr_o),
    .inta_i   (inta_i),
    .vector_o (vector_o)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wb_xfer(input logic we, input logic [3:0] adr,
                         input logic [15:0] wdat, output logic [15:0] rdat);
    bit got;
    got = 1'b0;
    rdat = '0;
    wb_adr = adr; wb_dat = wdat; wb_we = we;
    wb_sel = 2'b11; wb_stb = 1'b1; wb_cyc = 1'b1;
    for (int n = 0; n < 4 && !got; n++) begin
      @(posedge clk); #1;
      if (wb_ack_o) begin
        got = 1'b1;
        rdat = wb_dat_o;
      end
    end
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_we = 1'b0;
    if (!got) begin
      ncmp++; nfail++;
      $error("FAIL wb_timeout adr %h: observed no ack expected ack", adr);
    end
  endtask

  task automatic wr(input logic [3:0] adr, input logic [15:0] d);
    logic [15:0] dummy;
    wb_xfer(1'b1, adr, d, dummy);
  endtask

  task automatic rd(input string tag, input logic [3:0] adr,
                    input logic [15:0] exp);
    logic [15:0] r;
    wb_xfer(1'b0, adr, 16'h0, r);
    check(tag, r, exp);
  endtask

  task automatic pulse_int(input logic [3:0] m);
    int_i = int_i | m;
    tick(3);
    int_i = int_i & ~m;
    tick(1);
  endtask

  task automatic inta_pulse;
    inta_i = 1'b1;
    tick(1);
    ivec = vector_o;
    iintr = intr_o;
    tick(1);
    inta_i = 1'b0;
  endtask

  initial begin
    // Reset
    tick(2);
    check("rst_intr", {15'b0, intr_o}, 16'h0);
    check("rst_vec", {8'b0, vector_o}, 16'h0);
    check("rst_ack", {15'b0, wb_ack_o}, 16'h0);
    check("rst_dat", wb_dat_o, 16'h0);
    rst_b = 1'b1;
    tick(1);
    rd("i0con_rst", 4'hC, 16'h000F);
    rd("mask_rst", 4'h4, 16'h00F1);
    rd("inserv_rst", 4'h6, 16'h0000);
    rd("primsk_rst", 4'h5, 16'h0007);
    rd("unlisted_rd", 4'h8, 16'h0000);
    check("rst_intr_idle", {15'b0, intr_o}, 16'h0);

    // Edge request on INT0
    wr(4'hC, 16'h0002);
    pulse_int(4'b0001);
    check("t2_intr", {15'b0, intr_o}, 16'h1);
    check("t2_vec", {8'b0, vector_o}, 16'h000C);
    inta_pulse();
    check("t2_inta_intr", {15'b0, iintr}, 16'h0);
    check("t2_inta_vec", {8'b0, ivec}, 16'h000C);
    rd("t2_inserv", 4'h6, 16'h0010);
    rd("t2_reqst", 4'h7, 16'h0000);
    wr(4'h1, 16'h8000);
    rd("t2_inserv_eoi", 4'h6, 16'h0000);

    // Nesting: INT1 (PR1) in service blocks INT0 (PR2)
    wr(4'hD, 16'h0001);
    pulse_int(4'b0010);
    check("t3_vec1", {8'b0, vector_o}, 16'h000D);
    inta_pulse();
    rd("t3_inserv", 4'h6, 16'h0020);
    pulse_int(4'b0001);
    tick(2);
    check("t3_blocked", {15'b0, intr_o}, 16'h0);
    wr(4'h1, 16'h8000);
    tick(1);
    check("t3_intr_eoi", {15'b0, intr_o}, 16'h1);
    check("t3_vec_eoi", {8'b0, vector_o}, 16'h000C);
    inta_pulse();
    wr(4'h1, 16'h8000);
    rd("t3_clean", 4'h6, 16'h0000);

    // Equal priority tie, specific EOI
    wr(4'hC, 16'h0003);
    wr(4'hD, 16'h0003);
    pulse_int(4'b0011);
    check("t4_intr", {15'b0, intr_o}, 16'h1);
    inta_pulse();
    check("t4_vec_a", {8'b0, ivec}, 16'h000C);
    wr(4'h1, 16'h000C);
    tick(1);
    check("t4_intr_b", {15'b0, intr_o}, 16'h1);
    inta_pulse();
    check("t4_vec_b", {8'b0, ivec}, 16'h000D);
    rd("t4_inserv", 4'h6, 16'h0020);
    wr(4'h1, 16'h000D);
    rd("t4_clean", 4'h6, 16'h0000);

    // Level mode on INT2
    wr(4'hE, 16'h0011);
    int_i[2] = 1'b1;
    tick(4);
    check("t5_intr", {15'b0, intr_o}, 16'h1);
    check("t5_vec", {8'b0, vector_o}, 16'h000E);
    inta_pulse();
    rd("t5_inserv", 4'h6, 16'h0040);
    rd("t5_reqst_lvl", 4'h7, 16'h0040);
    check("t5_intr_busy", {15'b0, intr_o}, 16'h0);
    wr(4'h1, 16'h8000);
    tick(1);
    check("t5_rereq", {15'b0, intr_o}, 16'h1);
    inta_pulse();
    int_i[2] = 1'b0;
    tick(4);
    wr(4'h1, 16'h8000);
    tick(2);
    check("t5_no_rereq", {15'b0, intr_o}, 16'h0);
    rd("t5_reqst_low", 4'h7, 16'h0000);

    // Reset while inta is high
    int_i[2] = 1'b1;
    tick(4);
    check("t5_pre_rst", {15'b0, intr_o}, 16'h1);
    inta_i = 1'b1;
    tick(1);
    rst_b = 1'b0;
    int_i = '0;
    tick(1);
    check("t5_rst_intr", {15'b0, intr_o}, 16'h0);
    check("t5_rst_vec", {8'b0, vector_o}, 16'h0);
    check("t5_rst_ack", {15'b0, wb_ack_o}, 16'h0);
    check("t5_rst_dat", wb_dat_o, 16'h0);
    rst_b = 1'b1;
    inta_i = 1'b0;
    tick(1);
    rd("t5_rst_inserv", 4'h6, 16'h0000);
    rd("t5_rst_i2con", 4'hE, 16'h000F);

    // Timer source and MASK alias
    wr(4'h9, 16'h0000);
    tmr_i = 1'b1;
    tick(1);
    tmr_i = 1'b0;
    tick(1);
    check("tmr_intr", {15'b0, intr_o}, 16'h1);
    check("tmr_vec", {8'b0, vector_o}, 16'h0008);
    rd("tmr_reqst", 4'h7, 16'h0001);
    wr(4'h4, 16'h00F1);
    tick(1);
    check("tmr_masked", {15'b0, intr_o}, 16'h0);
    rd("tcucon_alias", 4'h9, 16'h0008);

    // POLL / POLLSTS
    wr(4'hF, 16'h0000);
    pulse_int(4'b1000);
    check("t6_intr", {15'b0, intr_o}, 16'h1);
    check("t6_vec", {8'b0, vector_o}, 16'h000F);
`ifdef ICU_POLL_EN
    rd("t6_pollsts", 4'h3, 16'h800F);
    rd("t6_inserv_pre", 4'h6, 16'h0000);
    rd("t6_poll", 4'h2, 16'h800F);
    rd("t6_inserv", 4'h6, 16'h0080);
`else
    rd("t6_pollsts", 4'h3, 16'h0000);
    rd("t6_poll", 4'h2, 16'h0000);
    rd("t6_inserv", 4'h6, 16'h0000);
    rd("t6_reqst", 4'h7, 16'h0081);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
